lc3_decode_stage: RTL and testbench
===================================

# lc3_decode_stage

Registered LC-3 decode pipeline stage. It sits between fetch and execute, captures the fetched instruction and NPC under `enable_decode`, and produces fully resolved execute, writeback and memory control words one cycle later. It replaces the earlier pure-function control decode with the following additions:
- full opcode coverage, including loads, stores and control flow
- deterministic zero fill for every don't-care field
- an illegal-opcode flag, a flush path, a valid bit and a decode counter

## Interface
- `MEM_OPS_EN`, default 1: 1 = decode LD/LDR/LDI/ST/STR/STI/BR/JMP; 0 = only ADD/AND/NOT/LEA are legal, everything else is flagged illegal.
- `CNT_W`, default 16: width of `decode_count`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enable_decode` in 1: capture `dout`/`npc_in` this cycle.
- `flush` in 1: kill the stage (branch redirect).
- `dout` in 16: fetched instruction.
- `npc_in` in 16: PC+1 of the fetched instruction.
- `IR` out 16: registered instruction.
- `npc_out` out 16: registered NPC.
- `E_Control` out 6: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control` out 2: 00 = ALU result, 01 = memory data, 10 = PC-adder result.
- `Mem_Control` out 3: {indirect, mem_op[1:0]}; mem_op 00 none, 01 load, 10 store.
- `reg_we` out 1: destination register write.
- `illegal` out 1: unsupported opcode captured.
- `valid_out` out 1: stage holds a live instruction.
- `decode_count` out CNT_W: count of captured instructions, wraps.

## Operation
- Field meanings:
  - alu_control: 00 ADD, 01 AND, 10 NOT.
  - pcselect1: 00 off11, 01 off9, 10 off6, 11 zero.
  - pcselect2: 1 = NPC, 0 = base register.
  - op2select: 1 = register, 0 = imm5.
- Every don't-care field is driven 0.
- Decode table (opcode = `dout[15:12]`; fields listed as E_Control / W_Control / Mem_Control / reg_we):
  - ADD 0001: E = 00000,~dout[5]; W = 00; Mem = 000; reg_we = 1.
  - AND 0101: E = 01000,~dout[5]; W = 00; Mem = 000; reg_we = 1.
  - NOT 1001: E = 100000; W = 00; Mem = 000; reg_we = 1.
  - LEA 1110: E = 000110; W = 10; Mem = 000; reg_we = 1.
  - LD 0010: E = 000110; W = 01; Mem = 001; reg_we = 1.
  - LDI 1010: E = 000110; W = 01; Mem = 101; reg_we = 1.
  - LDR 0110: E = 001000; W = 01; Mem = 001; reg_we = 1.
  - ST 0011: E = 000110; Mem = 010; reg_we = 0.
  - STI 1011: E = 000110; Mem = 110; reg_we = 0.
  - STR 0111: E = 001000; Mem = 010; reg_we = 0.
  - BR 0000: E = 000110; Mem = 000; reg_we = 0.
  - JMP 1100: E = 001100; Mem = 000; reg_we = 0.
  - For the non-ALU rows, any field not listed above (including W_Control on ST/STI/STR/BR/JMP) is 0.
- Illegal opcodes: 0100, 1000, 1101, 1111, plus every load/store/BR/JMP opcode when `MEM_OPS_EN` = 0.
  - Outputs: `illegal` = 1; E, W, Mem and `reg_we` all 0.
  - `IR`, `npc_out` and `valid_out` still load normally.
- Per-cycle state update, highest priority first:
  1. `reset`: every output goes to 0, including `decode_count`.
  2. `flush`: `valid_out` ← 0, `reg_we` ← 0, `Mem_Control` ← 0, `illegal` ← 0. Other registers hold. The counter does not increment, even when `enable_decode` = 1 in the same cycle.
  3. `enable_decode`: load `IR` ← `dout`, `npc_out` ← `npc_in`, all control outputs from the table, `valid_out` ← 1, `decode_count` ← `decode_count` + 1 (mod 2^CNT_W).
  4. Otherwise: all registers hold (stall).

## Timing
- Latency: one cycle. Values on `dout`/`npc_in` sampled at edge N are visible on the outputs after edge N.
- All outputs come straight from registers; there is no combinational path from input to output.
- A stall of any length holds every output bit-stable.
- Reset is sampled only on a rising edge. Reset asserted mid-stream clears the stage on the next edge regardless of `flush` or `enable_decode`.
- On the first edge after reset deasserts, the stage captures if `enable_decode` = 1.
- Back-to-back enables give one new decode per cycle with no bubble.
- Flush followed by enable on the next cycle resumes normally.

## Test plan
- Reset, then stall:
  - Stimulus: reset for 2 cycles, then `enable_decode` = 0.
  - Required: all outputs 0, `valid_out` = 0, `decode_count` = 0.
- ALU decode:
  - Stimulus: enable with `dout` = 16'h1042 (ADD register mode), then 16'h5060 (AND imm), then 16'h967F (NOT).
  - Required, cycle by cycle: E = 000001/W = 00, then E = 010000, then E = 100000; `reg_we` = 1 throughout; `decode_count` = 3.
- Memory decode:
  - Stimulus: LDI 16'hA005, then STR 16'h7042, then JMP 16'hC1C0.
  - Required: Mem = 101/W = 01; then E = 001000/Mem = 010/`reg_we` = 0; then E = 001100.
- Illegal opcodes:
  - Stimulus: 16'hF025 (TRAP) with `MEM_OPS_EN` = 1, then 16'h2005 (LD) with `MEM_OPS_EN` = 0.
  - Required: `illegal` = 1, controls 0, `valid_out` = 1, `IR` loaded.
- Flush versus enable:
  - Stimulus: `flush` and `enable_decode` both high while `dout` = 16'h1042.
  - Required: `valid_out` = 0, `reg_we` = 0, `decode_count` unchanged, `IR` unchanged.
- Counter wrap with reset:
  - Stimulus: `CNT_W` = 4, 17 consecutive enables.
  - Required: `decode_count` = 1.
  - Then assert reset during a stall; required: `decode_count` = 0 on the next edge.

Source files
------------

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers fetched IR/NPC and resolves execute/writeback/memory control words.
// Latency: one cycle from enable_decode to registered outputs; no combinational input-to-output path.
// Backpressure: none issued; enable_decode low stalls (all outputs hold), flush kills the live instruction.
module lc3_decode_stage #(
  parameter bit MEM_OPS_EN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic             flush,
  input  logic [15:0]      dout,
  input  logic [15:0]      npc_in,
  output logic [15:0]      IR,
  output logic [15:0]      npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic [2:0]       Mem_Control,
  output logic             reg_we,
  output logic             illegal,
  output logic             valid_out,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam logic [5:0] E_PC_OFF9 = 6'b000110;  // NPC + off9
  localparam logic [5:0] E_BR_OFF6 = 6'b001000;  // base reg + off6
  localparam logic [5:0] E_BR_ZERO = 6'b001100;  // base reg + 0

  logic [3:0]       opc;
  logic [5:0]       dec_e;
  logic [1:0]       dec_w;
  logic [2:0]       dec_m;
  logic             dec_we;
  logic             dec_ill;

  logic [15:0]      ir_d, ir_q;
  logic [15:0]      npc_d, npc_q;
  logic [5:0]       e_ctl_d, e_ctl_q;
  logic [1:0]       w_ctl_d, w_ctl_q;
  logic [2:0]       mem_ctl_d, mem_ctl_q;
  logic             reg_we_d, reg_we_q;
  logic             illegal_d, illegal_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] count_d, count_q;

  assign opc = dout[15:12];

  // Pure decode of the incoming instruction; every unused field stays zero.
  always_comb begin
    dec_e   = 6'b000000;
    dec_w   = 2'b00;
    dec_m   = 3'b000;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OP_ADD: begin
        dec_e  = {5'b00000, ~dout[5]};
        dec_we = 1'b1;
      end
      OP_AND: begin
        dec_e  = {5'b01000, ~dout[5]};
        dec_we = 1'b1;
      end
      OP_NOT: begin
        dec_e  = 6'b100000;
        dec_we = 1'b1;
      end
      OP_LEA: begin
        dec_e  = E_PC_OFF9;
        dec_w  = 2'b10;
        dec_we = 1'b1;
      end
      OP_LD: begin
        if (MEM_OPS_EN) begin
          dec_e  = E_PC_OFF9;
          dec_w  = 2'b01;
          dec_m  = 3'b001;
          dec_we = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LDI: begin
        if (MEM_OPS_EN) begin
          dec_e  = E_PC_OFF9;
          dec_w  = 2'b01;
          dec_m  = 3'b101;
          dec_we = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LDR: begin
        if (MEM_OPS_EN) begin
          dec_e  = E_BR_OFF6;
          dec_w  = 2'b01;
          dec_m  = 3'b001;
          dec_we = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_ST: begin
        if (MEM_OPS_EN) begin
          dec_e = E_PC_OFF9;
          dec_m = 3'b010;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STI: begin
        if (MEM_OPS_EN) begin
          dec_e = E_PC_OFF9;
          dec_m = 3'b110;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STR: begin
        if (MEM_OPS_EN) begin
          dec_e = E_BR_OFF6;
          dec_m = 3'b010;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_BR: begin
        if (MEM_OPS_EN) begin
          dec_e = E_PC_OFF9;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_JMP: begin
        if (MEM_OPS_EN) begin
          dec_e = E_BR_ZERO;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // Next-state selection: flush beats capture, otherwise hold.
  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    e_ctl_d   = e_ctl_q;
    w_ctl_d   = w_ctl_q;
    mem_ctl_d = mem_ctl_q;
    reg_we_d  = reg_we_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (flush) begin
      // Kill side effects only; IR/NPC and execute/writeback selects keep their last values.
      valid_d   = 1'b0;
      reg_we_d  = 1'b0;
      mem_ctl_d = 3'b000;
      illegal_d = 1'b0;
    end else if (enable_decode) begin
      ir_d      = dout;
      npc_d     = npc_in;
      e_ctl_d   = dec_e;
      w_ctl_d   = dec_w;
      mem_ctl_d = dec_m;
      reg_we_d  = dec_we;
      illegal_d = dec_ill;
      valid_d   = 1'b1;
      count_d   = count_q + CNT_W'(1);
    end
  end

  // Stage registers with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q      <= '0;
      npc_q     <= '0;
      e_ctl_q   <= '0;
      w_ctl_q   <= '0;
      mem_ctl_q <= '0;
      reg_we_q  <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      e_ctl_q   <= e_ctl_d;
      w_ctl_q   <= w_ctl_d;
      mem_ctl_q <= mem_ctl_d;
      reg_we_q  <= reg_we_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_ctl_q;
  assign W_Control    = w_ctl_q;
  assign Mem_Control  = mem_ctl_q;
  assign reg_we       = reg_we_q;
  assign illegal      = illegal_q;
  assign valid_out    = valid_q;
  assign decode_count = count_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: two instances (full decode, and ALU-only with a 4-bit counter)
// share one stimulus stream; expected observations are queued at issue time and checked by a monitor.
// Directed instruction vectors with hand-computed control words.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic        flush;
  logic [15:0] dout;
  logic [15:0] npc_in;

  logic [15:0] ir0, npc0, ir1, npc1;
  logic [5:0]  e0, e1;
  logic [1:0]  w0, w1;
  logic [2:0]  m0, m1;
  logic        we0, we1, ill0, ill1, vld0, vld1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  lc3_decode_stage #(.MEM_OPS_EN(1'b1), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .enable_decode(enable_decode), .flush(flush),
    .dout(dout), .npc_in(npc_in), .IR(ir0), .npc_out(npc0), .E_Control(e0),
    .W_Control(w0), .Mem_Control(m0), .reg_we(we0), .illegal(ill0),
    .valid_out(vld0), .decode_count(cnt0)
  );

  lc3_decode_stage #(.MEM_OPS_EN(1'b0), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .enable_decode(enable_decode), .flush(flush),
    .dout(dout), .npc_in(npc_in), .IR(ir1), .npc_out(npc1), .E_Control(e1),
    .W_Control(w1), .Mem_Control(m1), .reg_we(we1), .illegal(ill1),
    .valid_out(vld1), .decode_count(cnt1)
  );

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic [2:0]  m;
    logic        we;
    logic        ill;
    logic        vld;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    int   tgt;
    int   which;
    obs_t o;
  } rec_t;

  rec_t  sb[$];
  obs_t  x0, x1;
  obs_t  a0, a1;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  logic [15:0] np;

  assign a0 = '{ir: ir0, npc: npc0, e: e0, w: w0, m: m0, we: we0, ill: ill0, vld: vld0, cnt: cnt0};
  assign a1 = '{ir: ir1, npc: npc1, e: e1, w: w1, m: m1, we: we1, ill: ill1, vld: vld1, cnt: {12'h000, cnt1}};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int which, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, which, c, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation that targets the edge just taken.
  rec_t r;
  obs_t act;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].tgt == cyc) begin
      r   = sb.pop_front();
      act = (r.which == 0) ? a0 : a1;
      chk("IR",          r.which, cyc, act.ir,            r.o.ir);
      chk("npc_out",     r.which, cyc, act.npc,           r.o.npc);
      chk("E_Control",   r.which, cyc, {10'h0, act.e},    {10'h0, r.o.e});
      chk("W_Control",   r.which, cyc, {14'h0, act.w},    {14'h0, r.o.w});
      chk("Mem_Control", r.which, cyc, {13'h0, act.m},    {13'h0, r.o.m});
      chk("reg_we",      r.which, cyc, {15'h0, act.we},   {15'h0, r.o.we});
      chk("illegal",     r.which, cyc, {15'h0, act.ill},  {15'h0, r.o.ill});
      chk("valid_out",   r.which, cyc, {15'h0, act.vld},  {15'h0, r.o.vld});
      chk("decode_count",r.which, cyc, act.cnt,           r.o.cnt);
    end
  end

  // Drive one cycle of inputs and queue the expected post-edge state of both instances.
  task automatic go(input logic rr, input logic en, input logic fl, input logic [15:0] d, input logic [15:0] n);
    rec_t q;
    @(posedge clock);
    #1;
    reset = rr; enable_decode = en; flush = fl; dout = d; npc_in = n;
    q.tgt = cyc + 1;
    q.which = 0; q.o = x0; sb.push_back(q);
    q.which = 1; q.o = x1; q.o.cnt = x1.cnt & 16'h000F; sb.push_back(q);
  endtask

  // Capture: dut0 expectation given explicitly; dut1 gets the same if legal without memory ops, else illegal.
  task automatic cap(input logic [15:0] d, input logic [5:0] e, input logic [1:0] w, input logic [2:0] m,
                     input logic we, input logic ill, input logic legal1);
    np = np + 16'h1;
    x0.ir = d; x0.npc = np; x0.e = e; x0.w = w; x0.m = m; x0.we = we; x0.ill = ill; x0.vld = 1'b1;
    x0.cnt = x0.cnt + 16'h1;
    x1.ir = d; x1.npc = np; x1.vld = 1'b1; x1.cnt = x1.cnt + 16'h1;
    if (legal1) begin
      x1.e = e; x1.w = w; x1.m = m; x1.we = we; x1.ill = ill;
    end else begin
      x1.e = '0; x1.w = '0; x1.m = '0; x1.we = 1'b0; x1.ill = 1'b1;
    end
    go(1'b0, 1'b1, 1'b0, d, np);
  endtask

  task automatic flsh(input logic en, input logic [15:0] d);
    x0.vld = 1'b0; x0.we = 1'b0; x0.m = '0; x0.ill = 1'b0;
    x1.vld = 1'b0; x1.we = 1'b0; x1.m = '0; x1.ill = 1'b0;
    go(1'b0, en, 1'b1, d, 16'h7777);
  endtask

  task automatic stall();
    go(1'b0, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
  endtask

  task automatic rst(input logic en, input logic fl);
    x0 = '0; x1 = '0;
    go(1'b1, en, fl, 16'h1042, 16'h1111);
  endtask

  initial begin
    reset = 1'b1; enable_decode = 1'b0; flush = 1'b0; dout = 16'h0; npc_in = 16'h0;
    np = 16'h3000;
    x0 = '0; x1 = '0;

    // Reset for two cycles (second one with enable high), then a stall.
    rst(1'b0, 1'b0);
    rst(1'b1, 1'b0);
    stall();

    // ALU decode, back to back.
    cap(16'h1042, 6'b000001, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);  // ADD register
    cap(16'h5060, 6'b010000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);  // AND imm
    cap(16'h967F, 6'b100000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);  // NOT
    cap(16'h1025, 6'b000000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);  // ADD imm
    cap(16'hE1FF, 6'b000110, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1);  // LEA

    // Memory and control-flow decode (illegal on the ALU-only instance).
    cap(16'hA005, 6'b000110, 2'b01, 3'b101, 1'b1, 1'b0, 1'b0);  // LDI
    cap(16'h7042, 6'b001000, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);  // STR
    cap(16'hC1C0, 6'b001100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);  // JMP
    cap(16'h2005, 6'b000110, 2'b01, 3'b001, 1'b1, 1'b0, 1'b0);  // LD
    cap(16'h6042, 6'b001000, 2'b01, 3'b001, 1'b1, 1'b0, 1'b0);  // LDR
    cap(16'h3003, 6'b000110, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);  // ST
    cap(16'hB003, 6'b000110, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0);  // STI
    cap(16'h0E03, 6'b000110, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);  // BR

    // Always-illegal opcodes.
    cap(16'hF025, 6'b000000, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);  // TRAP
    cap(16'h4000, 6'b000000, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);  // JSR
    cap(16'h8000, 6'b000000, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);  // RTI
    cap(16'hD123, 6'b000000, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);  // reserved

    // Flush beats enable: clears illegal, then clears mem/reg_we of a live LDI.
    flsh(1'b1, 16'h1042);
    cap(16'hA005, 6'b000110, 2'b01, 3'b101, 1'b1, 1'b0, 1'b0);
    flsh(1'b1, 16'h1042);
    stall();
    stall();
    cap(16'h5060, 6'b010000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);  // resume after flush

    // Reset mid-stream wins over enable and flush, then 17 back-to-back enables.
    rst(1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cap(16'h1042, 6'b000001, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1);
    end
    stall();

    // Reset during a stall clears the counter.
    rst(1'b0, 1'b0);
    stall();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
